// File: rtl/ace_ccu_snoop_conflict_tracker_pkg.sv
// ace_ccu_snoop_conflict_tracker_pkg: shared defaults for the snoop conflict tracker
package ace_ccu_snoop_conflict_tracker_pkg;
  localparam int unsigned DefMaxTrans    = 4;
  localparam int unsigned DefCmAddrWidth = 58;
endpackage

// File: rtl/ace_ccu_snoop_conflict_tracker_lzc.sv
// ace_ccu_snoop_conflict_tracker_lzc: trailing-zero count, index of the lowest set bit
module ace_ccu_snoop_conflict_tracker_lzc
  import ace_ccu_snoop_conflict_tracker_pkg::*;
#(
  parameter int unsigned Width = DefMaxTrans
) (
  input  logic [Width-1:0]         in_i,
  output logic [$clog2(Width)-1:0] cnt_o
);
  localparam int unsigned CntW = $clog2(Width);
  // scan from the top so the lowest set bit wins
  always_comb begin
    cnt_o = '0;
    for (int i = Width - 1; i >= 0; i--) if (in_i[i]) cnt_o = CntW'(i);
  end
endmodule

// File: rtl/ace_ccu_snoop_conflict_tracker.sv
// ace_ccu_snoop_conflict_tracker: stalls snoops that hit an in-flight line or arrive while full
module ace_ccu_snoop_conflict_tracker
  import ace_ccu_snoop_conflict_tracker_pkg::*;
#(
  parameter int unsigned MaxTrans    = DefMaxTrans,
  parameter int unsigned CmAddrWidth = DefCmAddrWidth,
  parameter bit          InOrder     = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cm_valid_i,
  input  logic                            cm_ready_i,
  input  logic [CmAddrWidth-1:0]          cm_addr_i,
  output logic                            cm_stall_o,
  output logic [$clog2(MaxTrans)-1:0]     alloc_tag_o,
  input  logic                            done_i,
  input  logic [$clog2(MaxTrans)-1:0]     done_tag_i,
  output logic [$clog2(MaxTrans+1)-1:0]   usage_o,
  output logic                            err_o
);
  localparam int unsigned TagW = $clog2(MaxTrans);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  typedef logic [TagW-1:0] tag_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [MaxTrans-1:0]    valid_q, valid_d;
  logic [CmAddrWidth-1:0] addr_q [MaxTrans];
  tag_t                   wr_ptr_q, rd_ptr_q, free_tag, rel_tag;
  cnt_t                   usage_q;
  logic                   err_q, match, full, alloc, rel_ok;

  // a presented address conflicts if any live entry holds the same line
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < MaxTrans; i++) match |= valid_q[i] && (addr_q[i] == cm_addr_i);
  end

  ace_ccu_snoop_conflict_tracker_lzc #(.Width(MaxTrans)) u_free (
    .in_i (~valid_q),
    .cnt_o(free_tag)
  );

  assign full        = usage_q == cnt_t'(MaxTrans);
  assign cm_stall_o  = cm_valid_i && (match || full);
  assign alloc       = cm_valid_i && cm_ready_i && !cm_stall_o;
  assign alloc_tag_o = InOrder ? wr_ptr_q : free_tag;
  assign rel_tag     = InOrder ? rd_ptr_q : done_tag_i;
  assign rel_ok      = done_i && valid_q[rel_tag];
  assign usage_o     = usage_q;
  assign err_o       = err_q;

  // release and allocation never target the same entry: one needs it valid, the other free
  always_comb begin
    valid_d = valid_q;
    if (rel_ok) valid_d[rel_tag] = 1'b0;
    if (alloc) valid_d[alloc_tag_o] = 1'b1;
  end

  // entry table, pointers, occupancy and the delayed error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      addr_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      if (alloc) addr_q[alloc_tag_o] <= cm_addr_i;
      wr_ptr_q <= wr_ptr_q + tag_t'(alloc);
      rd_ptr_q <= rd_ptr_q + tag_t'(rel_ok);
      usage_q  <= usage_q + cnt_t'(alloc) - cnt_t'(rel_ok);
      err_q    <= done_i && !rel_ok;
    end
  end
endmodule
